// File: rtl/change_payout_if.sv
// -----------------------------------------------------------------------------
// change_payout_if
//
// Purpose:
//    Groups the controller-side and hopper-side signals of the change payout
//    block so that the block, the controller and a bench share one bundle.
//
// Handshake semantics (hopper side, four-phase req/ack):
//    1. The payout raises coin_req with coin set to the requested denomination.
//       coin does not change while coin_req is high.
//    2. The hopper ejects one coin and raises coin_ack. The coin counts as paid
//       in the first cycle the payout sees coin_ack high while coin_req is high.
//    3. The payout drops coin_req and drives coin back to 2'b00.
//    4. The hopper drops coin_ack. Only then may a new request be raised.
//    Controller side: load is a single-cycle strobe. change is sampled only in
//    the cycle load is high and the payout is idle.
//
// Signals:
//    change     controller -> payout   amount to pay in kurus
//    load       controller -> payout   start strobe
//    tl_empty   hopper     -> payout   1 TL tube empty
//    coin_ack   hopper     -> payout   hopper acknowledge
//    coin       payout     -> hopper   2'b01 = 50 kurus, 2'b10 = 1 TL, 2'b00 none
//    coin_req   payout     -> hopper   hopper request
//    busy       payout     -> controller
//    remaining  payout     -> controller  amount still to pay
//    done       payout     -> controller  one-cycle completion pulse
//    error      payout     -> controller  one-cycle reject pulse
//    fault      payout     -> controller  sticky handshake timeout flag
// -----------------------------------------------------------------------------
interface change_payout_if #(
   parameter int VALUE_W = 10
);
   logic [VALUE_W-1:0] change;
   logic               load;
   logic               tl_empty;
   logic               coin_ack;
   logic [1:0]         coin;
   logic               coin_req;
   logic               busy;
   logic [VALUE_W-1:0] remaining;
   logic               done;
   logic               error;
   logic               fault;

   // Controller/hopper side (drives the payout inputs).
   modport master (
      output change,
      output load,
      output tl_empty,
      output coin_ack,
      input  coin,
      input  coin_req,
      input  busy,
      input  remaining,
      input  done,
      input  error,
      input  fault
   );

   // Payout block side.
   modport slave (
      input  change,
      input  load,
      input  tl_empty,
      input  coin_ack,
      output coin,
      output coin_req,
      output busy,
      output remaining,
      output done,
      output error,
      output fault
   );
endinterface

// File: rtl/change_payout.sv
// -----------------------------------------------------------------------------
// change_payout
//
// Purpose:
//    Pays out a change amount (in kurus) as a sequence of coins through a
//    four-phase req/ack hopper handshake. The largest coin that fits is chosen
//    first (1 TL), falling back to 50 kurus when the 1 TL tube is empty.
//    Amounts that are not multiples of 50 are rejected with an error pulse.
//    Each handshake phase is guarded by a timeout; expiry parks the block in a
//    FAULT state that only reset leaves.
//
// Parameters:
//    ACK_TIMEOUT  cycles allowed per handshake phase (ack rise, ack fall)
//    VALUE_W      width of change/remaining; must match the interface
//
// Ports:
//    clk        system clock, rising edge
//    rst        asynchronous active-low reset
//    bus        change_payout_if slave modport (controller + hopper signals)
//    dbg_state  current FSM state encoding:
//               0 IDLE, 1 CHECK, 2 SELECT, 3 REQ, 4 RELEASE, 5 FIN, 6 FAULT
// -----------------------------------------------------------------------------
module change_payout #(
   parameter int ACK_TIMEOUT = 1000,
   parameter int VALUE_W     = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   change_payout_if.slave       bus,
   output logic [2:0]           dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CHECK   = 3'd1,
      S_SELECT  = 3'd2,
      S_REQ     = 3'd3,
      S_RELEASE = 3'd4,
      S_FIN     = 3'd5,
      S_FAULT   = 3'd6
   } state_t;

   localparam int                 CNT_W    = $clog2(ACK_TIMEOUT + 1);
   // Last counter value before a phase is declared timed out; the counter is
   // zero in the first cycle of a phase, so ACK_TIMEOUT cycles are allowed.
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [VALUE_W-1:0] V_50     = VALUE_W'(50);
   localparam logic [VALUE_W-1:0] V_100    = VALUE_W'(100);
   localparam logic [1:0]         COIN_NONE = 2'b00;
   localparam logic [1:0]         COIN_50   = 2'b01;
   localparam logic [1:0]         COIN_100  = 2'b10;

   state_t             state_q,     state_d;
   logic [VALUE_W-1:0] remaining_q, remaining_d;
   logic [1:0]         coin_q,      coin_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;

   logic               not_mult50;
   logic [VALUE_W-1:0] coin_value;

   // remaining holds the freshly latched change while in CHECK.
   assign not_mult50 = (remaining_q % V_50) != '0;
   assign coin_value = (coin_q == COIN_100) ? V_100 : V_50;

   // --------------------------------------------------------------------------
   // State and datapath registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         coin_q      <= COIN_NONE;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         coin_q      <= coin_d;
         cnt_q       <= cnt_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state and datapath logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      coin_d      = coin_q;
      cnt_d       = cnt_q;

      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (bus.load) begin
               remaining_d = bus.change;
               state_d     = S_CHECK;
            end
         end

         S_CHECK: begin
            if (not_mult50) begin
               remaining_d = '0;
               state_d     = S_IDLE;
            end else if (remaining_q == '0) begin
               state_d = S_FIN;
            end else begin
               state_d = S_SELECT;
            end
         end

         S_SELECT: begin
            // tl_empty is only looked at here, so it cannot disturb a coin
            // that is already being requested.
            if ((remaining_q >= V_100) && !bus.tl_empty) begin
               coin_d = COIN_100;
            end else begin
               coin_d = COIN_50;
            end
            cnt_d   = '0;
            state_d = S_REQ;
         end

         S_REQ: begin
            // An ack already high on entry is taken as the acknowledge.
            if (bus.coin_ack) begin
               remaining_d = remaining_q - coin_value;
               cnt_d       = '0;
               state_d     = S_RELEASE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_FAULT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_RELEASE: begin
            if (!bus.coin_ack) begin
               cnt_d   = '0;
               state_d = (remaining_q == '0) ? S_FIN : S_SELECT;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_FAULT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_FIN: begin
            state_d = S_IDLE;
         end

         S_FAULT: begin
            // Parked until reset; remaining is left frozen for diagnosis.
            state_d = S_FAULT;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Outputs (decoded from registered state)
   // --------------------------------------------------------------------------
   always_comb begin
      bus.coin      = COIN_NONE;
      bus.coin_req  = 1'b0;
      bus.busy      = 1'b0;
      bus.remaining = remaining_q;
      bus.done      = 1'b0;
      bus.error     = 1'b0;
      bus.fault     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
         end
         S_CHECK: begin
            // A rejected load never shows busy; the error pulse is the only
            // visible reaction.
            bus.busy  = !not_mult50;
            bus.error = not_mult50;
         end
         S_SELECT: begin
            bus.busy = 1'b1;
         end
         S_REQ: begin
            bus.busy     = 1'b1;
            bus.coin_req = 1'b1;
            bus.coin     = coin_q;
         end
         S_RELEASE: begin
            bus.busy = 1'b1;
         end
         S_FIN: begin
            bus.done = 1'b1;
         end
         S_FAULT: begin
            bus.busy  = 1'b1;
            bus.fault = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_change_payout.sv
module tb_change_payout;

   localparam int VW = 10;

   logic clk;
   logic rst;
   logic [2:0] dbg_state;

   change_payout_if #(.VALUE_W(VW)) bus ();

   change_payout #(
      .ACK_TIMEOUT(8),
      .VALUE_W    (VW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
      .dbg_state(dbg_state)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // Observations collected by the hopper model and monitor.
   logic [1:0]    got_coin_q[$];
   logic [VW-1:0] got_rem_q[$];
   logic [1:0]    exp_coin_q[$];
   logic [VW-1:0] exp_rem_q[$];
   int            done_cnt     = 0;
   int            err_cnt      = 0;
   int            req_rise_cnt = 0;
   int            coin_unstable = 0;
   logic          req_prev     = 1'b0;

   logic          hopper_en = 1'b0;
   int            ack_delay = 2;
   int            req_age   = 0;
   logic [1:0]    held_coin = 2'b00;

   // ---------------------------------------------------------------- clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- hopper model
   // Acks ack_delay cycles after seeing a request, drops ack once req drops.
   initial begin
      forever begin
         @(negedge clk);
         if (hopper_en) begin
            if (bus.coin_req && !bus.coin_ack) begin
               if (req_age == 0) begin
                  got_coin_q.push_back(bus.coin);
                  got_rem_q.push_back(bus.remaining);
                  held_coin = bus.coin;
               end else if (bus.coin !== held_coin) begin
                  coin_unstable++;
               end
               req_age++;
               if (req_age >= ack_delay) bus.coin_ack = 1'b1;
            end else if (!bus.coin_req && bus.coin_ack) begin
               bus.coin_ack = 1'b0;
               req_age      = 0;
            end
         end
      end
   end

   // ---------------------------------------------------------------- monitor
   always @(negedge clk) begin
      if (bus.done)  done_cnt++;
      if (bus.error) err_cnt++;
      if (bus.coin_req && !req_prev) req_rise_cnt++;
      req_prev = bus.coin_req;
   end

   // ---------------------------------------------------------------- drivers
   task automatic clear_obs();
      #1;
      got_coin_q.delete();
      got_rem_q.delete();
      done_cnt      = 0;
      err_cnt       = 0;
      req_rise_cnt  = 0;
      coin_unstable = 0;
   endtask

   // Returns at the negedge right after the load cycle.
   task automatic drive_load(input logic [VW-1:0] value);
      @(negedge clk);
      bus.change = value;
      bus.load   = 1'b1;
      @(negedge clk);
      bus.load   = 1'b0;
   endtask

   // Runs one payout; lat = cycles from load to first coin_req (-1 if none).
   task automatic run_payout(input logic [VW-1:0] value, input logic tl,
                             input int max_cycles, output logic seen,
                             output int lat);
      clear_obs();
      bus.tl_empty = tl;
      hopper_en    = 1'b1;
      seen         = 1'b0;
      lat          = -1;
      drive_load(value);
      for (int i = 1; i <= max_cycles; i++) begin
         if (i > 1) @(negedge clk);
         #1;
         if (lat < 0 && bus.coin_req) lat = i;
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
      repeat (3) @(negedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      rst = 1'b0;
      bus.change = '0; bus.load = 1'b0; bus.tl_empty = 1'b0; bus.coin_ack = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      tests_run++;
      if ({bus.coin, bus.coin_req, bus.busy, bus.remaining, bus.done, bus.error, bus.fault} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: coin=%0h req=%0b busy=%0b rem=%0d done=%0b err=%0b fault=%0b, required all 0",
                  bus.coin, bus.coin_req, bus.busy, bus.remaining, bus.done, bus.error, bus.fault);
      end
      tests_run++;
      if (dbg_state !== 3'd0) begin
         tests_failed++;
         $display("FAIL reset_state: got %0d required 0", dbg_state);
      end
      rst = 1'b1;
      clear_obs();
      repeat (10) @(negedge clk);
      #1;
      tests_run++;
      if (req_rise_cnt !== 0 || dbg_state !== 3'd0 || bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL idle_quiet: req_rises=%0d state=%0d busy=%0b, required 0/0/0",
                  req_rise_cnt, dbg_state, bus.busy);
      end
   endtask

   task automatic test_greedy_150();
      logic seen; int lat;
      run_payout(10'd150, 1'b0, 200, seen, lat);
      exp_coin_q = '{2'b10, 2'b01};
      exp_rem_q  = '{10'd150, 10'd50};
      tests_run++;
      if (seen !== 1'b1) begin tests_failed++; $display("FAIL p150_done_seen: got %0b required 1", seen); end
      tests_run++;
      if (lat !== 3) begin tests_failed++; $display("FAIL p150_latency: got %0d required 3", lat); end
      tests_run++;
      if (got_coin_q.size() !== exp_coin_q.size()) begin
         tests_failed++;
         $display("FAIL p150_coin_count: got %0d required %0d", got_coin_q.size(), exp_coin_q.size());
      end else begin
         for (int i = 0; i < exp_coin_q.size(); i++) begin
            tests_run++;
            if (got_coin_q[i] !== exp_coin_q[i]) begin tests_failed++; $display("FAIL p150_coin[%0d]: got %0h required %0h", i, got_coin_q[i], exp_coin_q[i]); end
            tests_run++;
            if (got_rem_q[i] !== exp_rem_q[i]) begin tests_failed++; $display("FAIL p150_rem[%0d]: got %0d required %0d", i, got_rem_q[i], exp_rem_q[i]); end
         end
      end
      tests_run++;
      if (done_cnt !== 1 || bus.busy !== 1'b0 || bus.remaining !== 10'd0 || coin_unstable !== 0) begin
         tests_failed++;
         $display("FAIL p150_end: done_cnt=%0d busy=%0b rem=%0d unstable=%0d, required 1/0/0/0",
                  done_cnt, bus.busy, bus.remaining, coin_unstable);
      end
   endtask

   task automatic test_tl_empty_200();
      logic seen; int lat;
      run_payout(10'd200, 1'b1, 300, seen, lat);
      exp_rem_q = '{10'd200, 10'd150, 10'd100, 10'd50};
      tests_run++;
      if (seen !== 1'b1 || done_cnt !== 1) begin tests_failed++; $display("FAIL p200_done: seen=%0b done_cnt=%0d required 1/1", seen, done_cnt); end
      tests_run++;
      if (got_coin_q.size() !== 4) begin
         tests_failed++;
         $display("FAIL p200_coin_count: got %0d required 4", got_coin_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (got_coin_q[i] !== 2'b01 || got_rem_q[i] !== exp_rem_q[i]) begin
               tests_failed++;
               $display("FAIL p200_coin[%0d]: got coin %0h rem %0d required coin 1 rem %0d",
                        i, got_coin_q[i], got_rem_q[i], exp_rem_q[i]);
            end
         end
      end
      tests_run++;
      if (bus.remaining !== 10'd0 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL p200_end: rem=%0d busy=%0b required 0/0", bus.remaining, bus.busy); end
   endtask

   task automatic test_zero_and_reject();
      clear_obs();
      drive_load(10'd0);
      #1;
      tests_run++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin tests_failed++; $display("FAIL zero_cycle1: done=%0b busy=%0b required 0/1", bus.done, bus.busy); end
      @(negedge clk); #1;
      tests_run++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL zero_done_cycle2: done=%0b busy=%0b required 1/0", bus.done, bus.busy); end
      repeat (4) @(negedge clk); #1;
      tests_run++;
      if (done_cnt !== 1 || req_rise_cnt !== 0) begin tests_failed++; $display("FAIL zero_counts: done=%0d req_rises=%0d required 1/0", done_cnt, req_rise_cnt); end

      // 75 and the maximum input 1023 are both non-multiples of 50.
      for (int k = 0; k < 2; k++) begin
         logic [VW-1:0] v;
         v = (k == 0) ? 10'd75 : 10'd1023;
         clear_obs();
         drive_load(v);
         #1;
         tests_run++;
         if (bus.error !== 1'b1 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reject_%0d_pulse: error=%0b busy=%0b required 1/0", v, bus.error, bus.busy); end
         @(negedge clk); #1;
         tests_run++;
         if (bus.error !== 1'b0 || bus.remaining !== 10'd0 || bus.busy !== 1'b0 || dbg_state !== 3'd0) begin
            tests_failed++;
            $display("FAIL reject_%0d_after: error=%0b rem=%0d busy=%0b state=%0d required 0/0/0/0",
                     v, bus.error, bus.remaining, bus.busy, dbg_state);
         end
         repeat (3) @(negedge clk); #1;
         tests_run++;
         if (err_cnt !== 1 || req_rise_cnt !== 0 || done_cnt !== 0) begin
            tests_failed++;
            $display("FAIL reject_%0d_counts: err=%0d req_rises=%0d done=%0d required 1/0/0", v, err_cnt, req_rise_cnt, done_cnt);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic seen; int lat;
      run_payout(10'd250, 1'b0, 300, seen, lat);
      exp_coin_q = '{2'b10, 2'b10, 2'b01};
      tests_run++;
      if (seen !== 1'b1 || got_coin_q.size() !== 3) begin
         tests_failed++;
         $display("FAIL p250_shape: seen=%0b coins=%0d required 1/3", seen, got_coin_q.size());
      end else begin
         tests_run++;
         if (got_coin_q[0] !== exp_coin_q[0] || got_coin_q[1] !== exp_coin_q[1] || got_coin_q[2] !== exp_coin_q[2]) begin
            tests_failed++;
            $display("FAIL p250_coins: got %0h %0h %0h required 2 2 1", got_coin_q[0], got_coin_q[1], got_coin_q[2]);
         end
      end
      run_payout(10'd1000, 1'b0, 600, seen, lat);
      tests_run++;
      if (seen !== 1'b1 || got_coin_q.size() !== 10 || done_cnt !== 1) begin
         tests_failed++;
         $display("FAIL p1000_shape: seen=%0b coins=%0d done=%0d required 1/10/1", seen, got_coin_q.size(), done_cnt);
      end else begin
         for (int i = 0; i < 10; i++) begin
            tests_run++;
            if (got_coin_q[i] !== 2'b10 || got_rem_q[i] !== 10'(1000 - 100 * i)) begin
               tests_failed++;
               $display("FAIL p1000_coin[%0d]: got coin %0h rem %0d required coin 2 rem %0d",
                        i, got_coin_q[i], got_rem_q[i], 1000 - 100 * i);
            end
         end
      end
   endtask

   task automatic test_timeout_fault();
      hopper_en    = 1'b0;
      bus.coin_ack = 1'b0;
      bus.tl_empty = 1'b0;
      clear_obs();
      drive_load(10'd100);
      repeat (9) @(negedge clk); #1;
      tests_run++;
      if (bus.coin_req !== 1'b1 || bus.fault !== 1'b0) begin tests_failed++; $display("FAIL to_last_req_cycle: req=%0b fault=%0b required 1/0", bus.coin_req, bus.fault); end
      @(negedge clk); #1;
      tests_run++;
      if (bus.fault !== 1'b1 || bus.coin_req !== 1'b0 || bus.remaining !== 10'd100 || bus.busy !== 1'b1 || bus.coin !== 2'b00) begin
         tests_failed++;
         $display("FAIL to_fault: fault=%0b req=%0b rem=%0d busy=%0b coin=%0h required 1/0/100/1/0",
                  bus.fault, bus.coin_req, bus.remaining, bus.busy, bus.coin);
      end
      drive_load(10'd50);
      repeat (5) @(negedge clk); #1;
      tests_run++;
      if (dbg_state !== 3'd6 || bus.remaining !== 10'd100 || bus.fault !== 1'b1 || req_rise_cnt !== 1) begin
         tests_failed++;
         $display("FAIL to_load_ignored: state=%0d rem=%0d fault=%0b req_rises=%0d required 6/100/1/1",
                  dbg_state, bus.remaining, bus.fault, req_rise_cnt);
      end
      rst = 1'b0;
      #1;
      tests_run++;
      if (bus.fault !== 1'b0 || bus.busy !== 1'b0 || bus.remaining !== 10'd0) begin
         tests_failed++;
         $display("FAIL to_reset_clears: fault=%0b busy=%0b rem=%0d required 0/0/0", bus.fault, bus.busy, bus.remaining);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset_mid_handshake();
      logic seen; int lat;
      hopper_en    = 1'b0;
      bus.coin_ack = 1'b0;
      clear_obs();
      drive_load(10'd100);
      repeat (2) @(negedge clk); #1;
      tests_run++;
      if (bus.coin_req !== 1'b1) begin tests_failed++; $display("FAIL mid_req_up: got %0b required 1", bus.coin_req); end
      #2 rst = 1'b0;
      #1;
      tests_run++;
      if (bus.coin_req !== 1'b0 || bus.remaining !== 10'd0 || bus.coin !== 2'b00) begin
         tests_failed++;
         $display("FAIL mid_async_drop: req=%0b rem=%0d coin=%0h required 0/0/0", bus.coin_req, bus.remaining, bus.coin);
      end
      @(negedge clk);
      rst = 1'b1;
      run_payout(10'd100, 1'b0, 200, seen, lat);
      tests_run++;
      if (seen !== 1'b1 || got_coin_q.size() !== 1 || lat !== 3) begin
         tests_failed++;
         $display("FAIL mid_reload: seen=%0b coins=%0d lat=%0d required 1/1/3", seen, got_coin_q.size(), lat);
      end else begin
         tests_run++;
         if (got_coin_q[0] !== 2'b10 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL mid_reload_coin: coin=%0h done=%0d required 2/1", got_coin_q[0], done_cnt);
         end
      end
   endtask

   // ---------------------------------------------------------------- sequence
   initial begin
      rst = 1'b0;
      bus.change = '0; bus.load = 1'b0; bus.tl_empty = 1'b0; bus.coin_ack = 1'b0;
      test_reset();
      test_greedy_150();
      test_tl_empty_200();
      test_zero_and_reject();
      test_back_to_back();
      test_timeout_fault();
      test_reset_mid_handshake();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
